// File: rtl/jellyvl_synctimer_time_sender.sv
// rtl/jellyvl_synctimer_time_sender.sv - frames the sampled master time into a checksummed byte-stream packet
module jellyvl_synctimer_time_sender #(
    parameter int                     TIMER_WIDTH  = 64,
    parameter int                     PERIOD_WIDTH = 32,
    parameter logic [TIMER_WIDTH-1:0] TIME_OFFSET  = '0,
    parameter logic [7:0]             HEADER       = 8'hA5
) (
    input  logic                    reset,
    input  logic                    clk,
    input  logic                    enable,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    send_request,
    input  logic [TIMER_WIDTH-1:0]  current_time,
    output logic [7:0]              m_data,
    output logic                    m_last,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    busy,
    output logic [7:0]              seq
);

    localparam int N     = TIMER_WIDTH / 8;
    localparam int IDX_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_TIME,
        ST_SUM
    } state_t;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
    logic                    pending_q, pending_d;
    logic [TIMER_WIDTH-1:0]  tsr_q, tsr_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [7:0]              sum_q, sum_d;
    logic [7:0]              seq_q, seq_d;
    logic                    valid_q, valid_d;
    logic [7:0]              data_q, data_d;
    logic                    last_q, last_d;

    logic trigger;
    logic accept;
    logic start;

    assign trigger = enable && (period != '0) && (cnt_q == '0);
    assign accept  = valid_q && m_ready;
    assign start   = (state_q == ST_IDLE) && pending_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            tsr_q     <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            seq_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            tsr_q     <= tsr_d;
            idx_q     <= idx_d;
            sum_q     <= sum_d;
            seq_q     <= seq_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (pending_q) state_d = ST_HDR;
            ST_HDR:  if (accept) state_d = ST_SEQ;
            ST_SEQ:  if (accept) state_d = ST_TIME;
            ST_TIME: if (accept && (idx_q == IDX_LAST)) state_d = ST_SUM;
            ST_SUM:  if (accept) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Requests arriving during a packet (or in the cycle it starts) stay queued as one.
    always_comb begin
        if (!enable || (period == '0)) begin
            cnt_d = '0;
        end else if (cnt_q == '0) begin
            cnt_d = period - PERIOD_WIDTH'(1);
        end else begin
            cnt_d = cnt_q - PERIOD_WIDTH'(1);
        end
        pending_d = (pending_q && !start) || trigger || send_request;
    end

    // Output bytes are registered one step ahead from the state being left.
    always_comb begin
        tsr_d   = tsr_q;
        idx_d   = idx_q;
        sum_d   = accept ? (sum_q + data_q) : sum_q;
        seq_d   = seq_q;
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    tsr_d   = current_time + TIME_OFFSET;
                    sum_d   = '0;
                    valid_d = 1'b1;
                    data_d  = HEADER;
                    last_d  = 1'b0;
                end
            end
            ST_HDR: begin
                if (accept) data_d = seq_q;
            end
            ST_SEQ: begin
                if (accept) begin
                    data_d = tsr_q[7:0];
                    tsr_d  = tsr_q >> 8;
                    idx_d  = '0;
                end
            end
            ST_TIME: begin
                if (accept) begin
                    if (idx_q == IDX_LAST) begin
                        data_d = sum_q + data_q;
                        last_d = 1'b1;
                    end else begin
                        data_d = tsr_q[7:0];
                        tsr_d  = tsr_q >> 8;
                        idx_d  = idx_q + IDX_W'(1);
                    end
                end
            end
            ST_SUM: begin
                if (accept) begin
                    valid_d = 1'b0;
                    data_d  = '0;
                    last_d  = 1'b0;
                    seq_d   = seq_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign m_data  = data_q;
    assign m_last  = last_q;
    assign m_valid = valid_q;
    assign busy    = (state_q != ST_IDLE);
    assign seq     = seq_q;

endmodule

// File: doc/jellyvl_synctimer_time_sender.md
# jellyvl_synctimer_time_sender

Master-side transmitter for the synctimer link. It samples the master's free-running `current_time`, either periodically or on request, and frames it into a byte-stream packet with a header, a sequence number, the timestamp and a checksum. The packet goes to the serial/link layer, whose remote end delivers `correct_time`/`correct_valid` to each slave's synctimer core. It is the sending counterpart of the slave-side correction path.

## Interface

Parameters:
- `TIMER_WIDTH`, 64, timestamp width; must be a multiple of 8 and ≥ 8
- `PERIOD_WIDTH`, 32, width of the send-interval counter
- `TIME_OFFSET`, 0, constant (TIMER_WIDTH bits) added to the sampled time to compensate link latency
- `HEADER`, 8'hA5, first byte of every packet

Ports:
- `reset`  in  1  asynchronous, active-low reset
- `clk`  in  1  clock
- `enable`  in  1  enables periodic sending
- `period`  in  PERIOD_WIDTH  send interval in clocks; 0 disables periodic sending
- `send_request`  in  1  one-cycle pulse requesting an immediate packet
- `current_time`  in  TIMER_WIDTH  master timer value
- `m_data`  out  8  packet byte
- `m_last`  out  1  high on the final (checksum) byte
- `m_valid`  out  1  byte valid
- `m_ready`  in  1  sink accepts the byte
- `busy`  out  1  a packet is in flight (state ≠ IDLE)
- `seq`  out  8  sequence number of the next or current packet

## Operation

- Packet layout, N = TIMER_WIDTH/8, total N+3 bytes:
  - `HEADER`
  - `seq`
  - timestamp, LSB first (N bytes)
  - checksum = sum of all preceding bytes, including the header, mod 256
- Interval counter (`cnt`, reset 0). When `enable` && `period`≠0:
  - `cnt`==0: trigger, then `cnt` ← `period`−1
  - otherwise: `cnt` ← `cnt`−1
- When `enable` is 0 or `period` is 0, `cnt` ← 0. The first trigger after enabling is therefore immediate.
- A `period` change takes effect at the next reload.
- `pending` flag:
  - Set by a trigger or by `send_request`.
  - Triggers that arrive while `pending` is already set, or while busy, merge into it (at most one queued packet).
  - Cleared when a packet starts.
- FSM states: IDLE, HDR, SEQ, TIME (byte index 0..N−1), SUM.
  - IDLE && `pending`: latch `tstamp` ← `current_time`+`TIME_OFFSET` (mod 2^TIMER_WIDTH), go to HDR.
  - HDR→SEQ→TIME[0]…TIME[N−1]→SUM→IDLE. Each step advances only on `m_valid`&&`m_ready`.
- `seq` increments (wrapping 255→0) when the SUM byte is accepted.
- The checksum accumulates each byte as it is accepted. The accumulator is cleared on entry to HDR.
- A trigger and a SUM acceptance in the same cycle: the trigger is kept in `pending`.

## Timing

- Reset values, applied asynchronously while `reset`=0:
  - `m_valid`=0, `m_last`=0, `m_data`=0
  - `busy`=0, `seq`=0
  - `pending`=0, `cnt`=0, state IDLE
- A reset mid-packet aborts the packet. `m_valid` drops without waiting for a clock.
- Latency:
  - Trigger or `send_request` sampled at edge T → `pending` set.
  - `tstamp` is taken from the `current_time` value present during cycle T+1.
  - The header appears with `m_valid`=1 from cycle T+2.
- Handshake:
  - `m_valid`, `m_data` and `m_last` are registered.
  - While `m_valid`&&!`m_ready`, they hold stable.
  - `m_valid` never drops mid-packet except on reset.
- Throughput:
  - With `m_ready` held at 1, one byte per clock.
  - At least one IDLE cycle between packets: last byte accepted at edge E → next header valid at E+2 at the earliest.
- `busy` is high from the cycle the header is valid until the cycle after the SUM byte is accepted.

## Test plan

1. Single request, defaults: `current_time`=64'h0123456789ABCDEF held constant, `m_ready`=1, `send_request` pulsed once. Required stream: A5,00,EF,CD,AB,89,67,45,23,01,65, with `m_last` only on 65. `seq` becomes 1 afterwards.
2. Backpressure: same stimulus with `m_ready` high one cycle in three. Required: identical bytes, and `m_data`/`m_last` unchanged during every stalled cycle.
3. Periodic: `period`=100, `enable`=1, `current_time` incrementing by 1 per clock. Required:
   - headers exactly 100 clocks apart
   - `seq` 0,1,2
   - consecutive timestamps differ by exactly 100
4. Merge: `send_request` pulsed 3 times while a packet is in flight. Required: exactly one further packet, with its header valid 2 clocks after SUM acceptance.
5. Wrap cases:
   - `TIME_OFFSET`=5 with `current_time`=2^64−2 gives timestamp 3.
   - After 256 packets `seq` reads 0 again.
6. Reset mid-packet: assert `reset`=0 after TIME[2] is accepted. Required: `m_valid` goes to 0 immediately. After release plus a request, the next packet starts with A5,00 (`seq` 0).
